// File: rtl/alu_share_ctrl.sv
// Shares one combinational ALU between two requesters (EX stage, aux unit); mul holds EXEC for MUL_CYCLES.
// Define ALU_SHARE_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module alu_share_ctrl #(
   parameter int MUL_CYCLES = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  req_valid,
   output logic [1:0]  req_ready,
   input  logic [9:0]  req_op,
   input  logic [63:0] req_a,
   input  logic [63:0] req_b,
   output logic [1:0]  rsp_valid,
   input  logic [1:0]  rsp_ready,
   output logic [31:0] rsp_result,
   output logic        rsp_zero,
   output logic [4:0]  alu_op,
   output logic [31:0] alu_data1,
   output logic [31:0] alu_data2,
   input  logic [31:0] alu_out,
   input  logic        alu_zero,
   output logic        busy
);

   localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
   localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
   localparam logic [4:0]       OP_MUL   = 5'd3;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t            state_q;
   logic              grant_q;
   logic [4:0]        op_q;
   logic [31:0]       a_q;
   logic [31:0]       b_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [31:0]       result_q;
   logic              zero_q;
   logic [1:0]        rsp_valid_q;
   logic              busy_q;
`ifdef ALU_SHARE_RR_EN
   logic              last_q;
`endif

   logic              grant_d;
   logic              accept_d;
   logic [4:0]        op_d;
   logic [31:0]       a_d;
   logic [31:0]       b_d;

   // Arbitration, ready handshake and operand selection for the granted requester
   always_comb begin
      grant_d = 1'b0;
      if (req_valid == 2'b11) begin
`ifdef ALU_SHARE_RR_EN
         grant_d = ~last_q;
`else
         grant_d = 1'b0;
`endif
      end else if (req_valid[1]) begin
         grant_d = 1'b1;
      end else begin
         grant_d = 1'b0;
      end

      accept_d = (state_q == S_IDLE) && (req_valid != 2'b00);

      req_ready = 2'b00;
      if (accept_d) begin
         req_ready = grant_d ? 2'b10 : 2'b01;
      end else begin
         req_ready = 2'b00;
      end

      op_d = grant_d ? req_op[9:5]  : req_op[4:0];
      a_d  = grant_d ? req_a[63:32] : req_a[31:0];
      b_d  = grant_d ? req_b[63:32] : req_b[31:0];
   end

   // Sequencer: accept, hold ALU inputs through EXEC, capture result, wait for response handshake
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         grant_q     <= 1'b0;
         op_q        <= 5'd0;
         a_q         <= 32'd0;
         b_q         <= 32'd0;
         cnt_q       <= CNT_ZERO;
         result_q    <= 32'd0;
         zero_q      <= 1'b0;
         rsp_valid_q <= 2'b00;
         busy_q      <= 1'b0;
`ifdef ALU_SHARE_RR_EN
         last_q      <= 1'b1;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accept_d) begin
                  grant_q <= grant_d;
                  op_q    <= op_d;
                  a_q     <= a_d;
                  b_q     <= b_d;
                  cnt_q   <= (op_d == OP_MUL) ? MUL_LOAD : CNT_ZERO;
                  busy_q  <= 1'b1;
                  state_q <= S_EXEC;
`ifdef ALU_SHARE_RR_EN
                  last_q  <= grant_d;
`endif
               end
            end
            S_EXEC: begin
               if (cnt_q != CNT_ZERO) begin
                  cnt_q <= cnt_q - CNT_ONE;
               end else begin
                  result_q    <= alu_out;
                  zero_q      <= alu_zero;
                  rsp_valid_q <= grant_q ? 2'b10 : 2'b01;
                  state_q     <= S_RESP;
               end
            end
            S_RESP: begin
               // Only the granted requester's rsp_ready closes the response
               if (rsp_ready[grant_q]) begin
                  rsp_valid_q <= 2'b00;
                  op_q        <= 5'd0;
                  a_q         <= 32'd0;
                  b_q         <= 32'd0;
                  busy_q      <= 1'b0;
                  state_q     <= S_IDLE;
               end
            end
            default: begin
               rsp_valid_q <= 2'b00;
               op_q        <= 5'd0;
               a_q         <= 32'd0;
               b_q         <= 32'd0;
               cnt_q       <= CNT_ZERO;
               busy_q      <= 1'b0;
               state_q     <= S_IDLE;
            end
         endcase
      end
   end

   assign rsp_valid  = rsp_valid_q;
   assign rsp_result = result_q;
   assign rsp_zero   = zero_q;
   assign alu_op     = op_q;
   assign alu_data1  = a_q;
   assign alu_data2  = b_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed self-checking bench for alu_share_ctrl with a behavioural ALU attached.
module tb_alu_share_ctrl;

   localparam int MUL_CYCLES = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [9:0]  req_op;
   logic [63:0] req_a;
   logic [63:0] req_b;
   logic [1:0]  rsp_valid;
   logic [1:0]  rsp_ready;
   logic [31:0] rsp_result;
   logic        rsp_zero;
   logic [4:0]  alu_op;
   logic [31:0] alu_data1;
   logic [31:0] alu_data2;
   logic [31:0] alu_out;
   logic        alu_zero;
   logic        busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // Behavioural ALU: add, sub, mul (truncated), B<<16; illegal ops give 0/0
   always_comb begin
      alu_out  = 32'd0;
      alu_zero = 1'b0;
      case (alu_op)
         5'd1: begin alu_out = alu_data1 + alu_data2; alu_zero = (alu_data1 == alu_data2); end
         5'd2: begin alu_out = alu_data1 - alu_data2; alu_zero = (alu_data1 == alu_data2); end
         5'd3: begin alu_out = alu_data1 * alu_data2; alu_zero = 1'b0; end
         5'd4: begin alu_out = alu_data2 << 16;       alu_zero = (alu_data1 != alu_data2); end
         default: begin alu_out = 32'd0; alu_zero = 1'b0; end
      endcase
   end

   alu_share_ctrl #(.MUL_CYCLES(MUL_CYCLES)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_a(req_a), .req_b(req_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .rsp_zero(rsp_zero),
      .alu_op(alu_op), .alu_data1(alu_data1), .alu_data2(alu_data2),
      .alu_out(alu_out), .alu_zero(alu_zero),
      .busy(busy)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a request and wait (bounded) for it to be accepted; returns one cycle after the accepting edge
   task automatic issue(input int r, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        output bit ok);
      req_op[5*r +: 5]  = op;
      req_a[32*r +: 32] = a;
      req_b[32*r +: 32] = b;
      req_valid[r]      = 1'b1;
      #1;
      ok = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (req_ready[r]) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      if (ok) tick();
      req_valid[r] = 1'b0;
   endtask

   task automatic test_reset();
      bit ok;
      bit seen;
      reset = 1'b1;
      rsp_ready = 2'b11;
      tick();
      tick();
      reset = 1'b0;
      #1;
      checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 00", rsp_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (alu_op !== 5'd0 || alu_data1 !== 32'd0 || alu_data2 !== 32'd0) begin errors++; $display("FAIL reset_alu: got op %0d d1 %h d2 %h expected 0", alu_op, alu_data1, alu_data2); end

      issue(0, 5'd3, 32'd7, 32'd6, ok);
      checks++; if (!ok) begin errors++; $display("FAIL reset_mul_accept: got no accept expected accept"); end
      tick();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      #1;
      checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL abort_rsp_valid: got %b expected 00", rsp_valid); end
      checks++; if (rsp_result !== 32'd0 || rsp_zero !== 1'b0) begin errors++; $display("FAIL abort_result: got %h/%b expected 0/0", rsp_result, rsp_zero); end
      checks++; if (busy !== 1'b0 || alu_op !== 5'd0) begin errors++; $display("FAIL abort_busy: got busy %b op %0d expected 0/0", busy, alu_op); end
      seen = 1'b0;
      repeat (6) begin
         tick();
         if (rsp_valid !== 2'b00) seen = 1'b1;
      end
      checks++; if (seen) begin errors++; $display("FAIL abort_no_rsp: got a response expected none"); end
   endtask

   task automatic test_add();
      bit ok;
      rsp_ready = 2'b11;
      issue(0, 5'd1, 32'd5, 32'd5, ok);
      checks++; if (!ok) begin errors++; $display("FAIL add_accept: got no accept expected accept"); end
      checks++; if (alu_op !== 5'd1 || alu_data1 !== 32'd5 || alu_data2 !== 32'd5 || busy !== 1'b1) begin errors++; $display("FAIL add_alu_in: got op %0d d1 %0d d2 %0d busy %b expected 1 5 5 1", alu_op, alu_data1, alu_data2, busy); end
      req_op[9:5] = 5'd1;
      req_valid = 2'b11;
      #1;
      checks++; if (req_ready !== 2'b00 || rsp_valid !== 2'b00) begin errors++; $display("FAIL add_exec: got ready %b valid %b expected 00 00", req_ready, rsp_valid); end
      tick();
      checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL add_latency: got valid %b expected 01", rsp_valid); end
      checks++; if (rsp_result !== 32'd10 || rsp_zero !== 1'b1) begin errors++; $display("FAIL add_result: got %0d/%b expected 10/1", rsp_result, rsp_zero); end
      checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL add_ready_resp: got %b expected 00", req_ready); end
      req_valid = 2'b00;
      tick();
      checks++; if (rsp_valid !== 2'b00 || busy !== 1'b0 || alu_op !== 5'd0) begin errors++; $display("FAIL add_idle: got valid %b busy %b op %0d expected 00 0 0", rsp_valid, busy, alu_op); end
   endtask

   task automatic test_mul();
      bit ok;
      bit stable;
      int n;
      rsp_ready = 2'b11;
      issue(1, 5'd3, 32'h0001_0000, 32'h0001_0000, ok);
      checks++; if (!ok) begin errors++; $display("FAIL mul_accept: got no accept expected accept"); end
      n = 0;
      stable = 1'b1;
      while (rsp_valid === 2'b00 && n < 12) begin
         if (alu_op !== 5'd3 || alu_data1 !== 32'h0001_0000 || alu_data2 !== 32'h0001_0000) stable = 1'b0;
         tick();
         n++;
      end
      checks++; if (n != 3) begin errors++; $display("FAIL mul_latency: got %0d edges expected 3", n); end
      checks++; if (!stable) begin errors++; $display("FAIL mul_alu_stable: got changing inputs expected stable"); end
      checks++; if (rsp_valid !== 2'b10 || rsp_result !== 32'd0 || rsp_zero !== 1'b0) begin errors++; $display("FAIL mul_result: got %b %h %b expected 10 0 0", rsp_valid, rsp_result, rsp_zero); end
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mul_idle: got busy %b expected 0", busy); end
   endtask

   task automatic test_backpressure();
      bit ok;
      bit held;
      rsp_ready = 2'b00;
      issue(0, 5'd2, 32'd9, 32'd4, ok);
      checks++; if (!ok) begin errors++; $display("FAIL bp_accept: got no accept expected accept"); end
      tick();
      req_op[9:5]    = 5'd1;
      req_a[63:32]   = 32'd1;
      req_b[63:32]   = 32'd2;
      req_valid      = 2'b10;
      rsp_ready      = 2'b10;
      #1;
      held = 1'b1;
      repeat (5) begin
         if (rsp_valid !== 2'b01 || rsp_result !== 32'd5 || rsp_zero !== 1'b0 || req_ready !== 2'b00 || busy !== 1'b1) held = 1'b0;
         tick();
      end
      checks++; if (!held) begin errors++; $display("FAIL bp_hold: got %b %0d %b ready %b expected 01 5 0 ready 00", rsp_valid, rsp_result, rsp_zero, req_ready); end
      rsp_ready = 2'b01;
      tick();
      checks++; if (rsp_valid !== 2'b00 || req_ready !== 2'b10) begin errors++; $display("FAIL bp_release: got valid %b ready %b expected 00 10", rsp_valid, req_ready); end
      tick();
      req_valid = 2'b00;
      tick();
      checks++; if (rsp_valid !== 2'b10 || rsp_result !== 32'd3 || rsp_zero !== 1'b0) begin errors++; $display("FAIL bp_req1: got %b %0d %b expected 10 3 0", rsp_valid, rsp_result, rsp_zero); end
      rsp_ready = 2'b11;
      tick();
   endtask

   task automatic test_tie();
      int exp_g[4];
      int n;
      int w;
      logic [1:0] exp_ready;
`ifdef ALU_SHARE_RR_EN
      n = 4; exp_g[0] = 0; exp_g[1] = 1; exp_g[2] = 0; exp_g[3] = 1;
`else
      n = 3; exp_g[0] = 0; exp_g[1] = 0; exp_g[2] = 0; exp_g[3] = 0;
`endif
      rsp_ready = 2'b11;
      req_op    = {5'd1, 5'd4};
      req_a     = {32'd2, 32'd0};
      req_b     = {32'd3, 32'd1};
      req_valid = 2'b11;
      #1;
      for (int k = 0; k < n; k++) begin
         w = 0;
         while (req_ready === 2'b00 && w < 6) begin
            tick();
            w++;
         end
         exp_ready = (exp_g[k] == 1) ? 2'b10 : 2'b01;
         checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL tie_grant%0d: got %b expected %b", k, req_ready, exp_ready); end
         tick();
         tick();
         if (exp_g[k] == 1) begin
            checks++; if (rsp_valid !== 2'b10 || rsp_result !== 32'd5 || rsp_zero !== 1'b0) begin errors++; $display("FAIL tie_rsp%0d: got %b %h %b expected 10 5 0", k, rsp_valid, rsp_result, rsp_zero); end
         end else begin
            checks++; if (rsp_valid !== 2'b01 || rsp_result !== 32'h0001_0000 || rsp_zero !== 1'b1) begin errors++; $display("FAIL tie_rsp%0d: got %b %h %b expected 01 10000 1", k, rsp_valid, rsp_result, rsp_zero); end
         end
         if (k == n - 1) req_valid = 2'b00;
         tick();
      end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tie_end_idle: got busy %b expected 0", busy); end
   endtask

   task automatic test_illegal();
      bit ok;
      rsp_ready = 2'b11;
      issue(0, 5'd9, 32'd3, 32'd3, ok);
      checks++; if (!ok) begin errors++; $display("FAIL ill_accept: got no accept expected accept"); end
      checks++; if (alu_op !== 5'd9) begin errors++; $display("FAIL ill_forward: got op %0d expected 9", alu_op); end
      tick();
      checks++; if (rsp_valid !== 2'b01 || rsp_result !== 32'd0 || rsp_zero !== 1'b0) begin errors++; $display("FAIL ill_result: got %b %h %b expected 01 0 0", rsp_valid, rsp_result, rsp_zero); end
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ill_idle: got busy %b expected 0", busy); end
   endtask

   initial begin
      reset     = 1'b1;
      req_valid = 2'b00;
      req_op    = 10'd0;
      req_a     = 64'd0;
      req_b     = 64'd0;
      rsp_ready = 2'b00;
      test_reset();
      test_add();
      test_mul();
      test_backpressure();
      test_tie();
      test_illegal();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
